// File: rtl/addpkg.sv
// Shared FP32 adder-front-end types: IEEE-754 single layout, requester ids,
// and the owner tag carried alongside each in-flight operation.
package addpkg;

  typedef struct packed {
    logic       sign;
    logic [7:0] exp;
    logic [22:0] frac;
  } ieee754_sp_t;

  typedef enum logic {
    REQ0 = 1'b0,
    REQ1 = 1'b1
  } fp_req_id_t;

  typedef struct packed {
    logic       vld;
    fp_req_id_t id;
  } fp_tag_t;

  // Only the sign bit changes, so NaN payloads, infinities and denormals pass through.
  function automatic ieee754_sp_t fp_negate(ieee754_sp_t x);
    ieee754_sp_t r;
    r      = x;
    r.sign = ~x.sign;
    return r;
  endfunction

endpackage

// File: rtl/fp_add_arbiter_tag_pipe.sv
// LAT-deep shift register of owner tags; the tail lines up with the adder's result strobe.
module fp_tag_pipe
  import addpkg::*;
#(
  parameter int LAT = 3
) (
  input  logic    clk,
  input  logic    rst,
  input  fp_tag_t tag_i,
  output fp_tag_t tail_o
);

  fp_tag_t stage_q [LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= tag_i;
      for (int i = 1; i < LAT; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign tail_o = stage_q[LAT-1];

endmodule

// File: rtl/fp_add_arbiter.sv
// Round-robin front end sharing one pipelined FP32 adder between two requesters,
// steering each result back to its owner through a tag pipeline.
module fp_add_arbiter
  import addpkg::*;
#(
  parameter int LAT = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     hold,
  input  logic                     req0_valid,
  output logic                     req0_ready,
  input  logic [31:0]              req0_a,
  input  logic [31:0]              req0_b,
  input  logic                     req0_sub,
  input  logic                     req1_valid,
  output logic                     req1_ready,
  input  logic [31:0]              req1_a,
  input  logic [31:0]              req1_b,
  input  logic                     req1_sub,
  output logic                     add_valid,
  output logic [31:0]              add_a,
  output logic [31:0]              add_b,
  input  logic                     add_res_valid,
  input  logic [31:0]              add_res,
  output logic                     rsp0_valid,
  output logic [31:0]              rsp0_result,
  output logic                     rsp1_valid,
  output logic [31:0]              rsp1_result,
  output logic                     seq_err,
  output logic [$clog2(LAT+2)-1:0] inflight
);

  localparam int CW = $clog2(LAT+2);

  fp_req_id_t  ptr_q, ptr_d;
  logic        gnt0, gnt1, gnt_any;
  ieee754_sp_t sel_a, sel_b, b_adj;
  logic        sel_sub;

  logic        add_valid_q;
  logic [31:0] add_a_q, add_b_q;
  fp_req_id_t  owner_q;

  fp_tag_t     tag_in, tail;
  logic        hit, mism;

  logic        rsp0_valid_q, rsp1_valid_q;
  logic [31:0] rsp0_result_q, rsp1_result_q;
  logic        seq_err_q;
  logic [CW-1:0] inflight_q, inflight_d;

  // Grant: a lone requester always wins; on contention the pointer decides.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!hold) begin
      if (req0_valid && req1_valid) begin
        gnt0 = (ptr_q == REQ0);
        gnt1 = (ptr_q == REQ1);
      end else begin
        gnt0 = req0_valid;
        gnt1 = req1_valid;
      end
    end
  end

  assign gnt_any    = gnt0 | gnt1;
  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  always_comb begin
    ptr_d = ptr_q;
    if (gnt0)      ptr_d = REQ1;
    else if (gnt1) ptr_d = REQ0;
  end

  always_comb begin
    sel_a   = ieee754_sp_t'(gnt1 ? req1_a : req0_a);
    sel_b   = ieee754_sp_t'(gnt1 ? req1_b : req0_b);
    sel_sub = gnt1 ? req1_sub : req0_sub;
    b_adj   = sel_sub ? fp_negate(sel_b) : sel_b;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= REQ0;
      add_valid_q <= 1'b0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      owner_q     <= REQ0;
    end else begin
      ptr_q       <= ptr_d;
      add_valid_q <= gnt_any;
      if (gnt_any) begin
        add_a_q <= sel_a;
        add_b_q <= b_adj;
        owner_q <= gnt1 ? REQ1 : REQ0;
      end
    end
  end

  always_comb begin
    tag_in     = '0;
    tag_in.vld = add_valid_q;
    tag_in.id  = owner_q;
  end

  fp_tag_pipe #(.LAT(LAT)) u_tag_pipe (
    .clk    (clk),
    .rst    (rst),
    .tag_i  (tag_in),
    .tail_o (tail)
  );

  assign hit  = add_res_valid & tail.vld;
  assign mism = add_res_valid ^ tail.vld;

  // The count follows tags leaving the pipe, so a missing result cannot strand it.
  always_comb begin
    inflight_d = inflight_q;
    if (gnt_any && !tail.vld)      inflight_d = inflight_q + CW'(1);
    else if (!gnt_any && tail.vld) inflight_d = inflight_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp0_valid_q  <= 1'b0;
      rsp1_valid_q  <= 1'b0;
      rsp0_result_q <= '0;
      rsp1_result_q <= '0;
      seq_err_q     <= 1'b0;
      inflight_q    <= '0;
    end else begin
      rsp0_valid_q <= hit && (tail.id == REQ0);
      rsp1_valid_q <= hit && (tail.id == REQ1);
      if (hit && (tail.id == REQ0)) rsp0_result_q <= add_res;
      if (hit && (tail.id == REQ1)) rsp1_result_q <= add_res;
      seq_err_q    <= seq_err_q | mism;
      inflight_q   <= inflight_d;
    end
  end

  assign add_valid   = add_valid_q;
  assign add_a       = add_a_q;
  assign add_b       = add_b_q;
  assign rsp0_valid  = rsp0_valid_q;
  assign rsp0_result = rsp0_result_q;
  assign rsp1_valid  = rsp1_valid_q;
  assign rsp1_result = rsp1_result_q;
  assign seq_err     = seq_err_q;
  assign inflight    = inflight_q;

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Scoreboard bench for fp_add_arbiter with a behavioural LAT-cycle FP adder model.
module tb_fp_add_arbiter;

  localparam int LAT = 3;
  localparam int CW  = $clog2(LAT+2);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          hold = 1'b0;
  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic          req0_ready, req1_ready;
  logic [31:0]   req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic          req0_sub = 1'b0, req1_sub = 1'b0;
  logic          add_valid;
  logic [31:0]   add_a, add_b;
  logic          add_res_valid;
  logic [31:0]   add_res;
  logic          rsp0_valid, rsp1_valid;
  logic [31:0]   rsp0_result, rsp1_result;
  logic          seq_err;
  logic [CW-1:0] inflight;
  logic          inj = 1'b0;

  fp_add_arbiter #(.LAT(LAT)) dut (
    .clk(clk), .rst(rst), .hold(hold),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sub(req0_sub),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sub(req1_sub),
    .add_valid(add_valid), .add_a(add_a), .add_b(add_b),
    .add_res_valid(add_res_valid), .add_res(add_res),
    .rsp0_valid(rsp0_valid), .rsp0_result(rsp0_result),
    .rsp1_valid(rsp1_valid), .rsp1_result(rsp1_result),
    .seq_err(seq_err), .inflight(inflight)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference FP add: widen to double, add, truncate back. Exponents of random
  // normal operands are kept in a range where this cannot over/underflow.
  function automatic logic [63:0] sp2dp(logic [31:0] x);
    return {x[31], {3'b000, x[30:23]} + 11'd896, x[22:0], 29'b0};
  endfunction

  function automatic logic [31:0] dp2sp(logic [63:0] d);
    logic [10:0] e;
    if (d[62:0] == 63'b0) return {d[63], 31'b0};
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] fpadd(logic [31:0] a, logic [31:0] b);
    real ra, rb;
    if (a[30:23] == 8'h00 || a[30:23] == 8'hFF || b[30:23] == 8'h00 || b[30:23] == 8'hFF)
      return a ^ b;
    ra = $bitstoreal(sp2dp(a));
    rb = $bitstoreal(sp2dp(b));
    return dp2sp($realtobits(ra + rb));
  endfunction

  function automatic logic [31:0] rand_fp();
    int k;
    k = $urandom_range(0, 15);
    case (k)
      0:       return 32'h7FC00001;
      1:       return 32'hFF800000;
      2:       return 32'h00000123;
      default: return {1'($urandom), 8'($urandom_range(110, 140)), 23'($urandom)};
    endcase
  endfunction

  // Behavioural adder: fixed latency, shares rst with the DUT.
  logic [LAT-1:0] pv;
  logic [31:0]    pd [LAT];
  always @(posedge clk) begin
    if (rst) pv <= '0;
    else     pv <= {pv[LAT-2:0], add_valid};
    pd[0] <= fpadd(add_a, add_b);
    for (int i = 1; i < LAT; i++) pd[i] <= pd[i-1];
  end
  assign add_res_valid = pv[LAT-1] | inj;
  assign add_res       = pd[LAT-1];

  typedef struct { int cyc; logic [31:0] a; logic [31:0] b; } iss_t;
  typedef struct { int cyc; bit owner; logic [31:0] res; } rsp_t;
  iss_t iss_q[$];
  rsp_t rsp_q[$];
  int   hs_q[$];
  bit   seq_m = 1'b0;
  bit   ptr_m = 1'b0;
  int   peak = 0;

  // Monitor: pops the scoreboard whenever an issue/response is due and checks the idle cycles too.
  always @(negedge clk) begin : mon
    iss_t ie;
    rsp_t re;
    bit   e0, e1;
    int   cnt;
    if (rst) begin
      iss_q.delete();
      rsp_q.delete();
      hs_q.delete();
      seq_m = 1'b0;
    end else begin
      if (iss_q.size() > 0 && iss_q[0].cyc == cyc) begin
        ie = iss_q.pop_front();
        check("add_valid", add_valid, 1);
        check("add_a", add_a, ie.a);
        check("add_b", add_b, ie.b);
      end else begin
        check("add_valid idle", add_valid, 0);
      end
      e0 = 1'b0; e1 = 1'b0; re.res = '0;
      if (rsp_q.size() > 0 && rsp_q[0].cyc == cyc) begin
        re = rsp_q.pop_front();
        e0 = !re.owner;
        e1 = re.owner;
      end
      check("rsp0_valid", rsp0_valid, e0);
      check("rsp1_valid", rsp1_valid, e1);
      if (e0) check("rsp0_result", rsp0_result, re.res);
      if (e1) check("rsp1_result", rsp1_result, re.res);
      while (hs_q.size() > 0 && hs_q[0] + 1 + LAT < cyc) void'(hs_q.pop_front());
      cnt = 0;
      foreach (hs_q[i]) if (hs_q[i] < cyc && cyc <= hs_q[i] + 1 + LAT) cnt++;
      check("inflight", inflight, cnt);
      check("seq_err", seq_err, seq_m);
      if (inj) seq_m = 1'b1;
    end
  end

  // Called at posedge+1: apply inputs, check grant against the round-robin model, record expectations.
  task automatic drive(input bit h, input bit v0, input bit v1,
                       input logic [31:0] a0, input logic [31:0] b0, input bit s0,
                       input logic [31:0] a1, input logic [31:0] b1, input bit s1,
                       input bit ovr, input logic [31:0] ovr_res);
    bit g0, g1, s;
    logic [31:0] a, b, bj;
    hold = h; req0_valid = v0; req1_valid = v1;
    req0_a = a0; req0_b = b0; req0_sub = s0;
    req1_a = a1; req1_b = b1; req1_sub = s1;
    @(negedge clk);
    g0 = 1'b0; g1 = 1'b0;
    if (!h) begin
      if (v0 && v1) begin g0 = (ptr_m == 1'b0); g1 = (ptr_m == 1'b1); end
      else begin g0 = v0; g1 = v1; end
    end
    check("req0_ready", req0_ready, g0);
    check("req1_ready", req1_ready, g1);
    if (g0 || g1) begin
      a  = g1 ? a1 : a0;
      b  = g1 ? b1 : b0;
      s  = g1 ? s1 : s0;
      bj = b ^ {s, 31'b0};
      iss_q.push_back('{cyc + 1, a, bj});
      rsp_q.push_back('{cyc + 2 + LAT, g1, ovr ? ovr_res : fpadd(a, bj)});
      hs_q.push_back(cyc);
      ptr_m = g0;
    end
    @(posedge clk); #1;
    if (int'(inflight) > peak) peak = int'(inflight);
  endtask

  task automatic idle(input bit h, input int n);
    repeat (n) drive(h, 0, 0, '0, '0, 0, '0, '0, 0, 0, '0);
  endtask

  task automatic both_rand(input bit h);
    drive(h, 1, 1, rand_fp(), rand_fp(), 1'($urandom), rand_fp(), rand_fp(), 1'($urandom), 0, '0);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1; hold = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; inj = 1'b0;
    ptr_m = 1'b0;
    repeat (n) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst add_valid", add_valid, 0);
    check("rst add_a", add_a, 0);
    check("rst add_b", add_b, 0);
    check("rst rsp0_valid", rsp0_valid, 0);
    check("rst rsp1_valid", rsp1_valid, 0);
    check("rst rsp0_result", rsp0_result, 0);
    check("rst rsp1_result", rsp1_result, 0);
    check("rst seq_err", seq_err, 0);
    check("rst inflight", inflight, 0);
    check("rst req0_ready", req0_ready, 0);
    check("rst req1_ready", req1_ready, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    do_reset(2);

    // Directed add on req0 and subtract on req1.
    drive(0, 1, 0, 32'h3F800000, 32'h40000000, 0, '0, '0, 0, 1, 32'h40400000);
    idle(0, LAT + 3);
    drive(0, 0, 1, '0, '0, 0, 32'h3F800000, 32'h40000000, 1, 1, 32'hBF800000);
    idle(0, LAT + 3);

    // Contention straight after reset: grants alternate starting at req0.
    do_reset(1);
    peak = 0;
    repeat (6) both_rand(0);
    idle(0, LAT + 3);
    check("inflight peak", peak, LAT + 1);

    // Hold with three operations in flight.
    repeat (3) both_rand(0);
    repeat (LAT + 3) both_rand(1);
    check("hold drained inflight", inflight, 0);

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      drive(($urandom_range(0, 7) == 0), 1'($urandom), 1'($urandom),
            rand_fp(), rand_fp(), 1'($urandom), rand_fp(), rand_fp(), 1'($urandom), 0, '0);
    end
    idle(0, LAT + 3);

    // Spurious adder result with an empty tag pipeline.
    inj = 1'b1;
    @(negedge clk);
    @(posedge clk); #1 inj = 1'b0;
    @(negedge clk);
    check("spurious seq_err", seq_err, 1);
    check("spurious rsp0_valid", rsp0_valid, 0);
    check("spurious rsp1_valid", rsp1_valid, 0);
    @(posedge clk); #1;
    both_rand(0);
    idle(0, LAT + 4);
    check("seq_err sticky", seq_err, 1);

    // Reset with two operations in flight.
    both_rand(0);
    both_rand(0);
    do_reset(1);
    idle(0, LAT + 3);
    drive(0, 1, 1, 32'h3F800000, 32'h3F800000, 0, 32'h40000000, 32'h40000000, 0, 1, 32'h40000000);
    idle(0, LAT + 3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
